// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle ARM core: state machine, NZCV flags, condition latch.
// Optional BL_LINK_EN: when defined, BL in BRANCH raises LinkWrite so the datapath writes R14.
//
// state    | meaning
// FETCH    | IR <- Mem[PC], PC <- PC+4
// DECODE   | read registers, latch condition result
// MEMADR   | ALU computes Rn + ExtImm address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to Rd
// MEMWRITE | store to memory at ALUOut
// EXECR    | ALU on Rn, Rm
// EXECI    | ALU on Rn, ExtImm
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <- PC+8+offset
// UNKNOWN  | undefined opcode, no writes

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       LinkWrite
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNKNOWN
    } state_t;

    state_t     state_q, state_d, st_out;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;
    logic       cond_pass;
    logic [1:0] alu_dp;
    logic       n_f, z_f, c_f, v_f;
    logic       in_exec, pc_dest;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign pc_dest = (Rd == 4'b1111);

    always_comb begin
        case (Funct[4:1])
            4'b0100: alu_dp = 2'b00;
            4'b0010: alu_dp = 2'b01;
            4'b0000: alu_dp = 2'b10;
            4'b1100: alu_dp = 2'b11;
            default: alu_dp = 2'b00;
        endcase
    end

    always_comb begin
        case (Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // C and V only follow the ALU for arithmetic ops; logical ops leave them alone.
    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        if (state_q == S_DECODE) condex_d = cond_pass;
        if (in_exec && condex_q && Funct[0]) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (alu_dp == 2'b00 || alu_dp == 2'b01) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // During reset the selects show FETCH values while every write enable is held low.
    always_comb begin
        st_out     = reset ? state_q : S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        LinkWrite  = 1'b0;
        ImmSrc     = (Op == 2'b01) ? 2'b01 : (Op == 2'b10) ? 2'b10 : 2'b00;
        RegSrc     = {(Op == 2'b01) && !Funct[0], Op == 2'b10};
        case (st_out)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condex_q;
                PCWrite   = condex_q & pc_dest;
            end
            S_EXECR:    ALUControl = alu_dp;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dp;
            end
            S_ALUWB: begin
                RegWrite = condex_q;
                PCWrite  = condex_q & pc_dest;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex_q;
`ifdef BL_LINK_EN
                LinkWrite = condex_q & Funct[4];
`else
                LinkWrite = 1'b0;
`endif
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            LinkWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors queued from a reference model.
module tb_multicycle_controller;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, UNKNOWN = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, LinkWrite;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [16:0] obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] sb[$];
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .LinkWrite(LinkWrite)
    );

    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, RegSrc, ALUControl, LinkWrite};

    function automatic logic [1:0] dp_op(input logic [5:0] fn);
        logic [3:0] cmd;
        cmd = fn[4:1];
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'b1110);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [16:0] exp_vec(input int st_in, input logic cx, input logic [1:0] op,
                                            input logic [5:0] fn, input logic [3:0] rd, input logic rst);
        logic pcw, mw, rw, irw, adr, sa, lw;
        logic [1:0] srcb, rs, imm, rsrc, ac;
        int st;
        st = rst ? st_in : FETCH;
        {pcw, mw, rw, irw, adr, sa, lw} = '0;
        {srcb, rs, ac} = '0;
        imm  = (op == 2'b00) ? 2'b00 : (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        rsrc = {(op == 2'b01) && (fn[0] == 1'b0), op == 2'b10};
        case (st)
            FETCH:    begin irw = 1; sa = 1; srcb = 2'b10; rs = 2'b10; pcw = 1; end
            DECODE:   begin sa = 1; srcb = 2'b10; rs = 2'b10; end
            MEMADR:   srcb = 2'b01;
            MEMREAD:  adr = 1;
            MEMWRITE: begin adr = 1; mw = cx; end
            MEMWB:    begin rs = 2'b01; rw = cx; pcw = cx && (rd == 4'hF); end
            EXECR:    ac = dp_op(fn);
            EXECI:    begin srcb = 2'b01; ac = dp_op(fn); end
            ALUWB:    begin rw = cx; pcw = cx && (rd == 4'hF); end
            BRANCH: begin
                srcb = 2'b01; rs = 2'b10; pcw = cx;
`ifdef BL_LINK_EN
                lw = cx && fn[4];
`endif
            end
            default: ;
        endcase
        if (!rst) {pcw, mw, rw, irw, lw} = '0;
        return {pcw, mw, rw, irw, adr, sa, srcb, rs, imm, rsrc, ac, lw};
    endfunction

    task automatic check_cycle(input string tag);
        logic [16:0] e;
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        n_checks++;
        assert (dut.flags_q === m_flags) else begin
            n_errors++;
            $error("FAIL %s: observed flags %b, expected flags %b", tag, dut.flags_q, m_flags);
        end
    endtask

    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
        int seq[$];
        logic cx;
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        cx = cond_ok(c, m_flags);
        seq = '{FETCH, DECODE};
        case (op)
            2'b00: begin seq.push_back(fn[5] ? EXECI : EXECR); seq.push_back(ALUWB); end
            2'b01: begin
                seq.push_back(MEMADR);
                if (fn[0]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
                else seq.push_back(MEMWRITE);
            end
            2'b10: seq.push_back(BRANCH);
            default: seq.push_back(UNKNOWN);
        endcase
        foreach (seq[i]) sb.push_back(exp_vec(seq[i], cx, op, fn, rd, 1'b1));
        foreach (seq[i]) check_cycle($sformatf("%s_cyc%0d", tag, i));
        if (op == 2'b00 && cx && fn[0]) begin
            m_flags[3:2] = af[3:2];
            if (dp_op(fn) == 2'b00 || dp_op(fn) == 2'b01) m_flags[1:0] = af[1:0];
        end
    endtask

    initial begin
        reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        m_flags = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(exp_vec(FETCH, 1'b0, Op, Funct, Rd, 1'b0));
        check_cycle("reset_init");
        reset = 1'b1;
        check_flags("reset_init_flags");

        run_instr("ldr_al", 4'hE, 2'b01, 6'b011001, 4'b0011, 4'b0000);
        run_instr("subs", 4'hE, 2'b00, 6'b000101, 4'b0010, 4'b0100);
        check_flags("subs_flags");
        run_instr("beq", 4'b0000, 2'b10, 6'b000000, 4'b0000, 4'b0000);
        run_instr("bne", 4'b0001, 2'b10, 6'b000000, 4'b0000, 4'b0000);

        // Abort an LDR mid-MEMREAD with two reset cycles; flags set by SUBS must clear.
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'b0100;
        sb.push_back(exp_vec(FETCH, 1'b1, Op, Funct, Rd, 1'b1));
        sb.push_back(exp_vec(DECODE, 1'b1, Op, Funct, Rd, 1'b1));
        sb.push_back(exp_vec(MEMADR, 1'b1, Op, Funct, Rd, 1'b1));
        check_cycle("rst_ldr_fetch");
        check_cycle("rst_ldr_decode");
        check_cycle("rst_ldr_memadr");
        reset = 1'b0;
        sb.push_back(exp_vec(MEMREAD, 1'b1, Op, Funct, Rd, 1'b0));
        sb.push_back(exp_vec(FETCH, 1'b1, Op, Funct, Rd, 1'b0));
        check_cycle("rst_hold0");
        check_cycle("rst_hold1");
        reset = 1'b1;
        m_flags = 4'b0000;
        check_flags("rst_mid_flags");

        run_instr("str_eq_fail", 4'b0000, 2'b01, 6'b011000, 4'b0101, 4'b0000);
        run_instr("add_r15", 4'hE, 2'b00, 6'b001000, 4'b1111, 4'b1111);
        check_flags("add_r15_flags");
        run_instr("subs_nv", 4'hE, 2'b00, 6'b000101, 4'b0001, 4'b1001);
        check_flags("subs_nv_flags");
        run_instr("bgt", 4'b1100, 2'b10, 6'b000000, 4'b0000, 4'b0000);
        run_instr("blt", 4'b1011, 2'b10, 6'b000000, 4'b0000, 4'b0000);
        run_instr("andsi", 4'hE, 2'b00, 6'b100001, 4'b0110, 4'b0110);
        check_flags("andsi_flags");
        run_instr("orr_ne", 4'b0001, 2'b00, 6'b011000, 4'b1111, 4'b0000);
        run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'b1111, 4'b0000);
        run_instr("bl_al", 4'hE, 2'b10, 6'b010000, 4'b0000, 4'b0000);
        run_instr("undef", 4'hE, 2'b11, 6'b000001, 4'b1111, 4'b1111);
        run_instr("after_undef", 4'hE, 2'b00, 6'b000101, 4'b0000, 4'b0000);
        check_flags("final_flags");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
